add4_sched: RTL and testbench

- Round-robin scheduler that shares one signed four-term adder (sum = c0 ± c1 ± c2 ± c3, 1-cycle registered latency) between NCH PWM channel requesters.
- For each accepted request it latches the channel's four contributions and three sign bits, drives them onto the adder, captures the adder's sum, and returns the sum tagged with the channel index.
- Sits between the per-channel contribution generators and the single shared adder instance.

---
 rtl/add4_pkg.sv | 33 +++
 rtl/add4_sched_rr_pick.sv | 38 +++
 rtl/add4_sched.sv | 158 +++++++++++++++
 tb/tb_add4_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/add4_pkg.sv
// ============================================================================
//  Module      : add4_pkg
//  Description : Shared types and FSM encodings for the four-term adder scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add4_pkg;

    localparam int W_DEF = 16;

    typedef logic [W_DEF-1:0] contrib_t;

    typedef struct packed {
        contrib_t c0;
        contrib_t c1;
        contrib_t c2;
        contrib_t c3;
        logic     c1s;
        logic     c2s;
        logic     c3s;
    } add4_op_t;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} sched_state_t;

    // Plain constants keep the state register a bare logic vector.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/add4_sched_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker; first set req bit at or
//                above ptr, wrapping modulo NCH.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import add4_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic           any,
    output logic [CW-1:0]  idx
);

    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        // Walk offsets downward so the smallest offset from ptr wins last.
        for (int i = NCH - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NCH;
            if (req[j]) begin
                any = 1'b1;
                idx = CW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/add4_sched.sv
// ============================================================================
//  Module      : add4_sched
//  Description : Round-robin scheduler sharing one registered four-term signed
//                adder between NCH requesting channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add4_sched
    import add4_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int CW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req,
    input  logic [NCH*4*W-1:0] ch_c,
    input  logic [NCH*3-1:0]   ch_s,
    output logic [NCH-1:0]     gnt,
    output logic [W-1:0]       add_c0,
    output logic [W-1:0]       add_c1,
    output logic [W-1:0]       add_c2,
    output logic [W-1:0]       add_c3,
    output logic               add_c1s,
    output logic               add_c2s,
    output logic               add_c3s,
    input  logic [W-1:0]       add_sum,
    output logic               res_valid,
    output logic [CW-1:0]      res_ch,
    output logic [W-1:0]       res_sum,
    output logic               busy
);

    logic [1:0]     r_state_q, w_state_d;
    logic [CW-1:0]  r_ptr_q,   w_ptr_d;
    logic [CW-1:0]  r_win_q,   w_win_d;
    logic [NCH-1:0] r_gnt_q,   w_gnt_d;
    logic [W-1:0]   r_c0_q, r_c1_q, r_c2_q, r_c3_q;
    logic [W-1:0]   w_c0_d, w_c1_d, w_c2_d, w_c3_d;
    logic           r_c1s_q, r_c2s_q, r_c3s_q;
    logic           w_c1s_d, w_c2s_d, w_c3s_d;
    logic           r_res_valid_q, w_res_valid_d;
    logic [CW-1:0]  r_res_ch_q,    w_res_ch_d;
    logic [W-1:0]   r_res_sum_q,   w_res_sum_d;

    logic           w_any;
    logic [CW-1:0]  w_idx;

    rr_pick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_rr_pick (
        .req (req),
        .ptr (r_ptr_q),
        .any (w_any),
        .idx (w_idx)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_win_d       = r_win_q;
        w_gnt_d       = '0;
        w_c0_d        = r_c0_q;
        w_c1_d        = r_c1_q;
        w_c2_d        = r_c2_q;
        w_c3_d        = r_c3_q;
        w_c1s_d       = r_c1s_q;
        w_c2s_d       = r_c2s_q;
        w_c3s_d       = r_c3s_q;
        w_res_valid_d = 1'b0;
        w_res_ch_d    = r_res_ch_q;
        w_res_sum_d   = r_res_sum_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_any) begin
                    w_c0_d    = ch_c[(int'(w_idx) * 4 + 0) * W +: W];
                    w_c1_d    = ch_c[(int'(w_idx) * 4 + 1) * W +: W];
                    w_c2_d    = ch_c[(int'(w_idx) * 4 + 2) * W +: W];
                    w_c3_d    = ch_c[(int'(w_idx) * 4 + 3) * W +: W];
                    w_c1s_d   = ch_s[int'(w_idx) * 3 + 2];
                    w_c2s_d   = ch_s[int'(w_idx) * 3 + 1];
                    w_c3s_d   = ch_s[int'(w_idx) * 3 + 0];
                    w_gnt_d   = NCH'(1) << w_idx;
                    w_win_d   = w_idx;
                    w_state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // The adder's registered sum of the operands latched at grant is valid now.
                w_res_sum_d   = add_sum;
                w_res_ch_d    = r_win_q;
                w_res_valid_d = 1'b1;
                w_ptr_d       = (r_win_q == CW'(NCH - 1)) ? '0 : r_win_q + CW'(1);
                w_state_d     = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_ptr_q       <= '0;
            r_win_q       <= '0;
            r_gnt_q       <= '0;
            r_c0_q        <= '0;
            r_c1_q        <= '0;
            r_c2_q        <= '0;
            r_c3_q        <= '0;
            r_c1s_q       <= 1'b0;
            r_c2s_q       <= 1'b0;
            r_c3s_q       <= 1'b0;
            r_res_valid_q <= 1'b0;
            r_res_ch_q    <= '0;
            r_res_sum_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_win_q       <= w_win_d;
            r_gnt_q       <= w_gnt_d;
            r_c0_q        <= w_c0_d;
            r_c1_q        <= w_c1_d;
            r_c2_q        <= w_c2_d;
            r_c3_q        <= w_c3_d;
            r_c1s_q       <= w_c1s_d;
            r_c2s_q       <= w_c2s_d;
            r_c3s_q       <= w_c3s_d;
            r_res_valid_q <= w_res_valid_d;
            r_res_ch_q    <= w_res_ch_d;
            r_res_sum_q   <= w_res_sum_d;
        end
    end

    assign gnt       = r_gnt_q;
    assign add_c0    = r_c0_q;
    assign add_c1    = r_c1_q;
    assign add_c2    = r_c2_q;
    assign add_c3    = r_c3_q;
    assign add_c1s   = r_c1s_q;
    assign add_c2s   = r_c2s_q;
    assign add_c3s   = r_c3s_q;
    assign res_valid = r_res_valid_q;
    assign res_ch    = r_res_ch_q;
    assign res_sum   = r_res_sum_q;
    assign busy      = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_add4_sched.sv
// ============================================================================
//  Module      : tb_add4_sched
//  Description : Directed self-checking bench for add4_sched with a model of
//                the shared registered four-term adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add4_sched;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int CW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     req;
    logic [NCH*4*W-1:0] ch_c;
    logic [NCH*3-1:0]   ch_s;
    logic [NCH-1:0]     gnt;
    logic [W-1:0]       add_c0, add_c1, add_c2, add_c3;
    logic               add_c1s, add_c2s, add_c3s;
    logic [W-1:0]       add_sum;
    logic               res_valid;
    logic [CW-1:0]      res_ch;
    logic [W-1:0]       res_sum;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int waited;

    always #5 clk = ~clk;

    add4_sched #(
        .NCH (NCH),
        .W   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ch_c      (ch_c),
        .ch_s      (ch_s),
        .gnt       (gnt),
        .add_c0    (add_c0),
        .add_c1    (add_c1),
        .add_c2    (add_c2),
        .add_c3    (add_c3),
        .add_c1s   (add_c1s),
        .add_c2s   (add_c2s),
        .add_c3s   (add_c3s),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_sum   (res_sum),
        .busy      (busy)
    );

    // Shared adder: one registered stage, modulo 2^W.
    always_ff @(posedge clk) begin
        add_sum <= add_c0 + (add_c1s ? -add_c1 : add_c1)
                          + (add_c2s ? -add_c2 : add_c2)
                          + (add_c3s ? -add_c3 : add_c3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] c0, input logic [W-1:0] c1,
                          input logic [W-1:0] c2, input logic [W-1:0] c3, input logic [2:0] s);
        ch_c[(i * 4 + 0) * W +: W] = c0;
        ch_c[(i * 4 + 1) * W +: W] = c1;
        ch_c[(i * 4 + 2) * W +: W] = c2;
        ch_c[(i * 4 + 3) * W +: W] = c3;
        ch_s[i * 3 +: 3]           = s;
    endtask

    // Waits for a grant, checks it, then follows the transaction to its result.
    task automatic serve(input int ch, input logic [W-1:0] c0, input logic [W-1:0] sum,
                         input bit drop, input bit corrupt, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 20);
        check("gnt", 32'(gnt), 32'(1) << ch);
        check("add_c0", 32'(add_c0), 32'(c0));
        check("busy_issue", 32'(busy), 32'd1);
        if (drop) req[ch] = 1'b0;
        if (corrupt) ch_c = ~ch_c;
        @(negedge clk);
        check("gnt_pulse", 32'(gnt), 32'd0);
        check("early_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_ch", 32'(res_ch), 32'(ch));
        check("res_sum", 32'(res_sum), 32'(sum));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ch_c  = '0;
        ch_s  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(res_sum), 32'd0);

        // Single request on ch2: 100 + 20 - 5 + 3 = 118
        set_ch(2, 16'd100, 16'd20, 16'd5, 16'd3, 3'b010);
        req = 4'b0100;
        serve(2, 16'd100, 16'd118, 1'b1, 1'b0, waited);
        check("ch2_wait", 32'(waited), 32'd1);
        @(negedge clk);
        check("valid_pulse", 32'(res_valid), 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);

        // Pointer now 3: req 0101 serves ch0 then ch2 back-to-back
        set_ch(0, 16'd1, 16'd2, 16'd3, 16'd4, 3'b000);
        set_ch(2, 16'd50, 16'd5, 16'd5, 16'd5, 3'b111);
        req = 4'b0101;
        serve(0, 16'd1, 16'd10, 1'b1, 1'b0, waited);
        serve(2, 16'd50, 16'd35, 1'b1, 1'b0, waited);
        check("rr_b2b", 32'(waited), 32'd1);

        // Wrap-around on ch3 (pointer 3)
        set_ch(3, 16'hFFFF, 16'd2, 16'd0, 16'd0, 3'b000);
        req = 4'b1000;
        serve(3, 16'hFFFF, 16'h0001, 1'b1, 1'b0, waited);

        // Underflow on ch0
        set_ch(0, 16'd0, 16'd1, 16'd0, 16'd0, 3'b111);
        req = 4'b0001;
        serve(0, 16'd0, 16'hFFFF, 1'b1, 1'b0, waited);

        // Data inverted the cycle after grant: 1000 - 1 + 2 + 3 = 1004
        set_ch(1, 16'd1000, 16'd1, 16'd2, 16'd3, 3'b100);
        req = 4'b0010;
        serve(1, 16'd1000, 16'd1004, 1'b1, 1'b1, waited);

        // Reset during ISSUE discards the transaction
        ch_c = '0;
        ch_s = '0;
        set_ch(2, 16'd7, 16'd0, 16'd0, 16'd0, 3'b000);
        req = 4'b0100;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 20);
        check("pre_rst_gnt", 32'(gnt), 32'b0100);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_c0", 32'(add_c0), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_valid", 32'(res_valid), 32'd0);
        end

        // All requests held: rotation 0,1,2,3,0,1 with back-to-back grants
        for (int i = 0; i < NCH; i++) set_ch(i, W'(i * 10), 16'd0, 16'd0, 16'd0, 3'b000);
        req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            serve(n % NCH, W'((n % NCH) * 10), W'((n % NCH) * 10), 1'b0, 1'b0, waited);
            check("fair_wait", 32'(waited), 32'd1);
        end
        req = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
